// File: rtl/mem_unit.sv
// Single-port 16-bit word memory with a ready handshake and configurable wait states.
// Optional byte lanes, sign-extended byte reads and misaligned-word err are enabled by `define BYTE_ACCESS_EN.
module mem_unit #(
    parameter int          ADDR_W      = 6,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] INIT_WORD0  = 16'b0000001011110000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       in,
    input  logic              write,
    input  logic              read,
    input  logic              word,
    output logic [15:0]       out,
    output logic              ready,
    output logic              err
);

    localparam int         WORDS    = 2 ** (ADDR_W - 1);
    localparam int         IDX_W    = ADDR_W - 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_count;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_data;
    logic              r_isWrite;
    logic              r_ready;
    logic [15:0]       r_out;

    // Power-up image only; reset deliberately leaves the array alone.
    logic [15:0] r_mem [0:WORDS-1] = '{0: INIT_WORD0, default: 16'h0000};

    logic        w_req;
    logic        w_misaligned;
    logic [15:0] w_rdWord;
    logic [15:0] w_rdData;
    logic [15:0] w_wrData;

    assign w_req    = !write || !read;
    assign w_rdWord = r_mem[r_idx];

`ifdef BYTE_ACCESS_EN
    logic       r_word;
    logic       r_lane;
    logic       r_err;
    logic [7:0] w_rdByte;

    assign w_misaligned = word && address[0];
    assign w_rdByte     = r_lane ? w_rdWord[15:8] : w_rdWord[7:0];
    assign w_rdData     = r_word ? w_rdWord : {{8{w_rdByte[7]}}, w_rdByte};
    // Byte writes merge into the current word so the untouched lane is preserved.
    assign w_wrData     = r_word ? r_data :
                          (r_lane ? {r_data[7:0], w_rdWord[7:0]} : {w_rdWord[15:8], r_data[7:0]});
    assign err          = r_err;
`else
    logic w_unused;

    assign w_unused     = &{1'b0, word, address[0]};
    assign w_misaligned = 1'b0;
    assign w_rdData     = w_rdWord;
    assign w_wrData     = r_data;
    assign err          = 1'b0;
`endif

    assign out   = r_out;
    assign ready = r_ready;

    // An async reset forces IDLE, so an aborted access can never reach DONE here.
    always_ff @(posedge clk) begin
        if (r_state == DONE && r_isWrite) begin
            r_mem[r_idx] <= w_wrData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_idx     <= '0;
            r_data    <= 16'h0000;
            r_isWrite <= 1'b0;
            r_ready   <= 1'b0;
            r_out     <= 16'h0000;
`ifdef BYTE_ACCESS_EN
            r_word    <= 1'b0;
            r_lane    <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
`ifdef BYTE_ACCESS_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_misaligned) begin
`ifdef BYTE_ACCESS_EN
                            r_err <= 1'b1;
`endif
                        end else begin
                            r_idx     <= address[ADDR_W-1:1];
                            r_data    <= in;
                            r_isWrite <= !write;
`ifdef BYTE_ACCESS_EN
                            r_word    <= word;
                            r_lane    <= address[0];
`endif
                            r_count   <= WAIT_CNT;
                            r_state   <= (WAIT_CNT == 4'd0) ? DONE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    if (!r_isWrite) begin
                        r_out <= w_rdData;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit: one instance with 1 wait state, one with 3.
// Byte-lane expectations follow the BYTE_ACCESS_EN build option.
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [5:0]  addrA = 6'd0, addrB = 6'd0;
    logic [15:0] inA = 16'h0000, inB = 16'h0000;
    logic        writeA = 1'b1, readA = 1'b1, wordA = 1'b1;
    logic        writeB = 1'b1, readB = 1'b1, wordB = 1'b1;
    logic [15:0] outA, outB;
    logic        readyA, readyB, errA, errB;

    int testsRun = 0;
    int testsFailed = 0;

`ifdef BYTE_ACCESS_EN
    localparam logic [15:0] EXP10 = 16'h12EF;
    localparam logic [15:0] PRIOR_OUT = 16'h0F0F;
`else
    localparam logic [15:0] EXP10 = 16'hBEEF;
    localparam logic [15:0] PRIOR_OUT = 16'h1234;
`endif

    mem_unit #(.ADDR_W(6), .WAIT_CYCLES(1), .INIT_WORD0(16'b0000001011110000)) dutA (
        .clk(clk), .reset(reset), .address(addrA), .in(inA), .write(writeA), .read(readA),
        .word(wordA), .out(outA), .ready(readyA), .err(errA)
    );

    mem_unit #(.ADDR_W(6), .WAIT_CYCLES(3), .INIT_WORD0(16'b0000001011110000)) dutB (
        .clk(clk), .reset(reset), .address(addrB), .in(inB), .write(writeB), .read(readB),
        .word(wordB), .out(outB), .ready(readyB), .err(errB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues one request on instance sel (0=A, 1=B) and reports edges-to-ready (-1 if none) and err cycles.
    task automatic applyStimulus(input int sel, input logic wr_n, input logic rd_n, input logic wd,
                                 input logic [5:0] addr, input logic [15:0] data,
                                 output int lat, output int errCycles);
        @(negedge clk);
        if (sel == 0) begin
            writeA = wr_n; readA = rd_n; wordA = wd; addrA = addr; inA = data;
        end else begin
            writeB = wr_n; readB = rd_n; wordB = wd; addrB = addr; inB = data;
        end
        @(posedge clk); #1;
        writeA = 1'b1; readA = 1'b1; addrA = 6'h3F; inA = 16'hDEAD;
        writeB = 1'b1; readB = 1'b1; addrB = 6'h3F; inB = 16'hDEAD;
        errCycles = ((sel == 0) ? errA : errB) ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? errA : errB) errCycles++;
            if ((sel == 0) ? readyA : readyB) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (outA !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_outA: got %h, expected %h", outA, 16'h0000); end
        testsRun++;
        if (readyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_readyA: got %b, expected 0", readyA); end
        testsRun++;
        if (errA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_errA: got %b, expected 0", errA); end
        testsRun++;
        if (outB !== 16'h0000 || readyB !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_B: got out=%h ready=%b, expected 0000/0", outB, readyB); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_power_up();
        int lat, ec;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd0, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 2) begin testsFailed++; $display("[TB] FAIL powerup_latency: got %0d, expected 2", lat); end
        testsRun++;
        if (outA !== 16'h02F0) begin testsFailed++; $display("[TB] FAIL powerup_data: got %h, expected 02f0", outA); end
    endtask

    task automatic test_word_rw();
        int lat, ec;
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 6'd10, 16'hBEEF, lat, ec);
        testsRun++;
        if (lat !== 2) begin testsFailed++; $display("[TB] FAIL wordwr_latency: got %0d, expected 2", lat); end
        testsRun++;
        if (outA !== 16'h02F0) begin testsFailed++; $display("[TB] FAIL wordwr_out_kept: got %h, expected 02f0", outA); end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 2 || outA !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL wordrd_A: got lat=%0d out=%h, expected 2/beef", lat, outA); end
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 6'd10, 16'hC0DE, lat, ec);
        testsRun++;
        if (lat !== 4) begin testsFailed++; $display("[TB] FAIL wordwr_B_latency: got %0d, expected 4", lat); end
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 4 || outB !== 16'hC0DE) begin testsFailed++; $display("[TB] FAIL wordrd_B: got lat=%0d out=%h, expected 4/c0de", lat, outB); end
    endtask

    task automatic test_byte_lanes();
        int lat, ec;
`ifdef BYTE_ACCESS_EN
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 6'd11, 16'hAB12, lat, ec);
        testsRun++;
        if (lat !== 2) begin testsFailed++; $display("[TB] FAIL bytewr_latency: got %0d, expected 2", lat); end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== 16'h12EF) begin testsFailed++; $display("[TB] FAIL byte_merge: got %h, expected 12ef", outA); end
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 6'd10, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== 16'hFFEF) begin testsFailed++; $display("[TB] FAIL byterd_low_sext: got %h, expected ffef", outA); end
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 6'd11, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== 16'h0012) begin testsFailed++; $display("[TB] FAIL byterd_high: got %h, expected 0012", outA); end
`else
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 6'd11, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 2 || outA !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL word_ignored: got lat=%0d out=%h, expected 2/beef", lat, outA); end
        testsRun++;
        if (ec !== 0) begin testsFailed++; $display("[TB] FAIL no_err_default: got %0d err cycles, expected 0", ec); end
`endif
    endtask

    task automatic test_misaligned();
        int lat, ec;
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 6'd2, 16'h0F0F, lat, ec);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 6'd3, 16'h1234, lat, ec);
`ifdef BYTE_ACCESS_EN
        testsRun++;
        if (ec !== 1) begin testsFailed++; $display("[TB] FAIL misaligned_err: got %0d err cycles, expected 1", ec); end
        testsRun++;
        if (lat !== -1) begin testsFailed++; $display("[TB] FAIL misaligned_ready: got ready after %0d edges, expected none", lat); end
`else
        testsRun++;
        if (ec !== 0 || lat !== 2) begin testsFailed++; $display("[TB] FAIL odd_addr_word: got err=%0d lat=%0d, expected 0/2", ec, lat); end
`endif
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd2, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== PRIOR_OUT) begin testsFailed++; $display("[TB] FAIL misaligned_readback: got %h, expected %h", outA, PRIOR_OUT); end
    endtask

    task automatic test_priority();
        int lat, ec;
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 6'd14, 16'h5555, lat, ec);
        testsRun++;
        if (lat !== 2 || outA !== PRIOR_OUT) begin testsFailed++; $display("[TB] FAIL priority_out: got lat=%0d out=%h, expected 2/%h", lat, outA, PRIOR_OUT); end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd14, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== 16'h5555) begin testsFailed++; $display("[TB] FAIL priority_write: got %h, expected 5555", outA); end
    endtask

    task automatic test_back_to_back();
        int lat, ec;
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 6'd16, 16'h1111, lat, ec);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd16, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 2 || outA !== 16'h1111) begin testsFailed++; $display("[TB] FAIL back_to_back: got lat=%0d out=%h, expected 2/1111", lat, outA); end
    endtask

    task automatic test_ignore_strobes();
        int lat, ec;
        int pulses = 0;
        int readyAt = -1;
        @(negedge clk);
        writeB = 1'b0; readB = 1'b1; wordB = 1'b1; addrB = 6'd8; inB = 16'h5A5A;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                writeB = (i % 2 == 0); readB = (i % 2 == 1); addrB = 6'd12; inB = 16'hFFFF;
            end else begin
                writeB = 1'b1; readB = 1'b1;
            end
            @(posedge clk); #1;
            if (readyB) begin
                pulses++;
                if (readyAt < 0) readyAt = i;
            end
        end
        testsRun++;
        if (pulses !== 1 || readyAt !== 4) begin testsFailed++; $display("[TB] FAIL ignore_ready: got %0d pulses first at %0d, expected 1 at 4", pulses, readyAt); end
        testsRun++;
        if (outB !== 16'hC0DE) begin testsFailed++; $display("[TB] FAIL ignore_out_kept: got %h, expected c0de", outB); end
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 6'd8, 16'h0000, lat, ec);
        testsRun++;
        if (outB !== 16'h5A5A) begin testsFailed++; $display("[TB] FAIL ignore_latched: got %h, expected 5a5a", outB); end
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 6'd12, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 4 || outB !== 16'h0000) begin testsFailed++; $display("[TB] FAIL ignore_no_write: got lat=%0d out=%h, expected 4/0000", lat, outB); end
    endtask

    task automatic test_reset_mid();
        int lat, ec;
        int pulses = 0;
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 6'd0, 16'h0000, lat, ec);
        @(negedge clk);
        writeB = 1'b0; readB = 1'b1; wordB = 1'b1; addrB = 6'd20; inB = 16'hAAAA;
        @(posedge clk); #1;
        writeB = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        testsRun++;
        if (outB !== 16'h0000 || readyB !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_outputs: got out=%h ready=%b, expected 0000/0", outB, readyB); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (readyB) pulses++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (readyB) pulses++;
        end
        testsRun++;
        if (pulses !== 0) begin testsFailed++; $display("[TB] FAIL midreset_ready: got %0d pulses, expected 0", pulses); end
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 6'd20, 16'h0000, lat, ec);
        testsRun++;
        if (lat !== 4 || outB !== 16'h0000) begin testsFailed++; $display("[TB] FAIL midreset_no_write: got lat=%0d out=%h, expected 4/0000", lat, outB); end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, lat, ec);
        testsRun++;
        if (outA !== EXP10) begin testsFailed++; $display("[TB] FAIL array_survives_reset: got %h, expected %h", outA, EXP10); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_word_rw();
        test_byte_lanes();
        test_misaligned();
        test_priority();
        test_back_to_back();
        test_ignore_strobes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
